// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, function codes,
// ALU operations, datapath mux selects, FSM states and decoded-instruction info.
package mc_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;

    localparam logic [4:0] ALU_NOP = 5'd0;
    localparam logic [4:0] ALU_ADD = 5'd1;
    localparam logic [4:0] ALU_SUB = 5'd2;
    localparam logic [4:0] ALU_AND = 5'd3;
    localparam logic [4:0] ALU_OR  = 5'd4;
    localparam logic [4:0] ALU_SLT = 5'd5;
    localparam logic [4:0] ALU_SLL = 5'd6;
    localparam logic [4:0] ALU_SRL = 5'd7;
    localparam logic [4:0] ALU_SRA = 5'd8;
    localparam logic [4:0] ALU_LUI = 5'd9;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_REG = 2'b11;

    localparam logic [1:0] WD_ALU  = 2'b00;
    localparam logic [1:0] WD_MEM  = 2'b01;
    localparam logic [1:0] WD_PC   = 2'b10;

    localparam logic [1:0] GPR_RD  = 2'b00;
    localparam logic [1:0] GPR_RT  = 2'b01;
    localparam logic [1:0] GPR_31  = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        C_RALU, C_SHIFT, C_IALU, C_LW, C_SW, C_BEQ, C_BNE,
        C_J, C_JAL, C_JR, C_JALR
    } iclass_e;

    typedef struct packed {
        iclass_e    iclass;
        logic [4:0] alu_op;
        logic       ext_op;
        logic       alu_src;
        logic       areg_sel;
        logic       legal;
    } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: Op/Funct to instruction class and the
// execute-stage ALU controls.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec.iclass   = C_RALU;
        dec.alu_op   = ALU_NOP;
        dec.ext_op   = 1'b0;
        dec.alu_src  = 1'b0;
        dec.areg_sel = 1'b0;
        dec.legal    = 1'b1;
        case (op)
            OP_R: begin
                case (funct)
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    FN_SLL: begin dec.iclass = C_SHIFT; dec.alu_op = ALU_SLL; dec.areg_sel = 1'b1; end
                    FN_SRL: begin dec.iclass = C_SHIFT; dec.alu_op = ALU_SRL; dec.areg_sel = 1'b1; end
                    FN_SRA: begin dec.iclass = C_SHIFT; dec.alu_op = ALU_SRA; dec.areg_sel = 1'b1; end
                    FN_JR:   dec.iclass = C_JR;
                    FN_JALR: dec.iclass = C_JALR;
                    default: dec.legal = 1'b0;
                endcase
            end
            // Arithmetic immediates sign-extend, logical ones zero-extend.
            OP_ADDI: begin dec.iclass = C_IALU; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.ext_op = 1'b1; end
            OP_SLTI: begin dec.iclass = C_IALU; dec.alu_op = ALU_SLT; dec.alu_src = 1'b1; dec.ext_op = 1'b1; end
            OP_ANDI: begin dec.iclass = C_IALU; dec.alu_op = ALU_AND; dec.alu_src = 1'b1; end
            OP_ORI:  begin dec.iclass = C_IALU; dec.alu_op = ALU_OR;  dec.alu_src = 1'b1; end
            OP_LUI:  begin dec.iclass = C_IALU; dec.alu_op = ALU_LUI; dec.alu_src = 1'b1; end
            OP_LW:   begin dec.iclass = C_LW;   dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.ext_op = 1'b1; end
            OP_SW:   begin dec.iclass = C_SW;   dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.ext_op = 1'b1; end
            OP_BEQ:  begin dec.iclass = C_BEQ;  dec.alu_op = ALU_SUB; end
            OP_BNE:  begin dec.iclass = C_BNE;  dec.alu_op = ALU_SUB; end
            OP_J:    dec.iclass = C_J;
            OP_JAL:  dec.iclass = C_JAL;
            default: dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM (FETCH/DECODE/EXE/MEM/WB) sequencing the shared-memory
// datapath, with a retired-instruction counter and memory-timeout fault.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             RegWrite,
    output logic             EXTOp,
    output logic [4:0]       ALUOp,
    output logic [1:0]       NPCOp,
    output logic [1:0]       WDSel,
    output logic [1:0]       GPRSel,
    output logic             ALUSrc,
    output logic             ARegSel,
    output logic [2:0]       state,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e              state_q, state_d;
    logic [1:0]          fault_q, fault_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    retired_q;
    logic                stall;
    logic                retire;
    dec_t                dec;
    logic                unused_instr_bits;

    assign unused_instr_bits = ^instr[25:6];

    mc_decode u_decode (
        .op    (instr[31:26]),
        .funct (instr[5:0]),
        .dec   (dec)
    );

    // Memory handshake: MemRead/MemWrite and IorD stay asserted and steady
    // until the cycle mem_ready is high, which completes the access.
    always_comb begin
        state_d  = state_q;
        fault_d  = fault_q;
        wait_d   = '0;
        stall    = 1'b0;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        RegWrite = 1'b0;
        EXTOp    = 1'b0;
        ALUOp    = ALU_NOP;
        NPCOp    = NPC_PC4;
        WDSel    = WD_ALU;
        GPRSel   = GPR_RD;
        ALUSrc   = 1'b0;
        ARegSel  = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    stall = 1'b1;
                end
            end
            S_DECODE: begin
                if (!dec.legal) begin
                    state_d = S_FAULT;
                    fault_d = FAULT_ILLEGAL;
                end else begin
                    case (dec.iclass)
                        C_J:   begin PCWrite = 1'b1; NPCOp = NPC_J; state_d = S_FETCH; end
                        C_JAL: begin
                            PCWrite  = 1'b1; NPCOp  = NPC_J;
                            RegWrite = 1'b1; GPRSel = GPR_31; WDSel = WD_PC;
                            state_d  = S_FETCH;
                        end
                        C_JR:  begin PCWrite = 1'b1; NPCOp = NPC_REG; state_d = S_FETCH; end
                        // PC already holds old PC+4, so the link value is written
                        // the same cycle PC loads RD1.
                        C_JALR: begin
                            PCWrite  = 1'b1; NPCOp  = NPC_REG;
                            RegWrite = 1'b1; GPRSel = GPR_RD; WDSel = WD_PC;
                            state_d  = S_FETCH;
                        end
                        default: state_d = S_EXE;
                    endcase
                end
            end
            S_EXE: begin
                ALUOp   = dec.alu_op;
                ALUSrc  = dec.alu_src;
                ARegSel = dec.areg_sel;
                EXTOp   = dec.ext_op;
                case (dec.iclass)
                    C_BEQ: begin
                        if (Zero) begin PCWrite = 1'b1; NPCOp = NPC_BR; end
                        state_d = S_FETCH;
                    end
                    C_BNE: begin
                        if (!Zero) begin PCWrite = 1'b1; NPCOp = NPC_BR; end
                        state_d = S_FETCH;
                    end
                    C_LW, C_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                IorD = 1'b1;
                if (dec.iclass == C_LW) MemRead = 1'b1;
                else                    MemWrite = 1'b1;
                if (mem_ready) state_d = (dec.iclass == C_LW) ? S_WB : S_FETCH;
                else           stall = 1'b1;
            end
            S_WB: begin
                RegWrite = 1'b1;
                if (dec.iclass == C_LW) begin
                    WDSel = WD_MEM; GPRSel = GPR_RT;
                end else if (dec.iclass == C_IALU) begin
                    GPRSel = GPR_RT;
                end
                state_d = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase

        if (stall && TIMEOUT != 0) begin
            if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                state_d = S_FAULT;
                fault_d = FAULT_TIMEOUT;
            end else begin
                wait_d = wait_q + WAIT_W'(1);
            end
        end

        // Reset must silence every enable even though the held state is FETCH.
        if (!rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign retire = (state_d == S_FETCH) && (state_q != S_FETCH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            fault_q   <= FAULT_NONE;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            wait_q  <= wait_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign state   = state_q;
    assign fault   = fault_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized self-checking bench for mc_ctrl against a per-instruction phase
// model; a second instance covers TIMEOUT = 0 and counter wrap (CNT_W = 3).
module tb_mc_ctrl;

    typedef enum int {
        K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_SLL, K_SRL, K_SRA, K_JR, K_JALR,
        K_ADDI, K_SLTI, K_ANDI, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL,
        K_N
    } kind_e;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       ext_op;
        logic [4:0] alu_op;
        logic [1:0] npc_op;
        logic [1:0] wd_sel;
        logic [1:0] gpr_sel;
        logic       alu_src;
        logic       areg_sel;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = '0;
    logic        Zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic        PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, EXTOp, ALUSrc, ARegSel;
    logic [4:0]  ALUOp;
    logic [1:0]  NPCOp, WDSel, GPRSel, fault;
    logic [2:0]  state;
    logic [31:0] retired;

    logic        nt_pc_write, nt_ir_write, nt_mem_read, nt_mem_write, nt_iord, nt_reg_write;
    logic        nt_ext_op, nt_alu_src, nt_areg_sel;
    logic [4:0]  nt_alu_op;
    logic [1:0]  nt_npc_op, nt_wd_sel, nt_gpr_sel, nt_fault;
    logic [2:0]  nt_state;
    logic [2:0]  nt_retired;

    ctl_t dut_ctl, nt_ctl;
    int   checks = 0;
    int   errors = 0;
    int   n_retired = 0;

    assign dut_ctl = {PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, EXTOp,
                      ALUOp, NPCOp, WDSel, GPRSel, ALUSrc, ARegSel};
    assign nt_ctl  = {nt_pc_write, nt_ir_write, nt_mem_read, nt_mem_write, nt_iord,
                      nt_reg_write, nt_ext_op, nt_alu_op, nt_npc_op, nt_wd_sel,
                      nt_gpr_sel, nt_alu_src, nt_areg_sel};

    mc_ctrl #(.TIMEOUT(16), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .IorD(IorD), .RegWrite(RegWrite), .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp),
        .WDSel(WDSel), .GPRSel(GPRSel), .ALUSrc(ALUSrc), .ARegSel(ARegSel),
        .state(state), .fault(fault), .retired(retired)
    );

    mc_ctrl #(.TIMEOUT(0), .CNT_W(3)) u_nt (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(nt_pc_write), .IRWrite(nt_ir_write), .MemRead(nt_mem_read),
        .MemWrite(nt_mem_write), .IorD(nt_iord), .RegWrite(nt_reg_write),
        .EXTOp(nt_ext_op), .ALUOp(nt_alu_op), .NPCOp(nt_npc_op), .WDSel(nt_wd_sel),
        .GPRSel(nt_gpr_sel), .ALUSrc(nt_alu_src), .ARegSel(nt_areg_sel),
        .state(nt_state), .fault(nt_fault), .retired(nt_retired)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] funct_of(kind_e k);
        case (k)
            K_ADD:   return 6'h20;
            K_SUB:   return 6'h22;
            K_AND:   return 6'h24;
            K_OR:    return 6'h25;
            K_SLT:   return 6'h2A;
            K_SLL:   return 6'h00;
            K_SRL:   return 6'h02;
            K_SRA:   return 6'h03;
            K_JR:    return 6'h08;
            default: return 6'h09;
        endcase
    endfunction

    function automatic logic [5:0] op_of(kind_e k);
        case (k)
            K_ADDI:  return 6'h08;
            K_SLTI:  return 6'h0A;
            K_ANDI:  return 6'h0C;
            K_ORI:   return 6'h0D;
            K_LUI:   return 6'h0F;
            K_LW:    return 6'h23;
            K_SW:    return 6'h2B;
            K_BEQ:   return 6'h04;
            K_BNE:   return 6'h05;
            K_J:     return 6'h02;
            K_JAL:   return 6'h03;
            default: return 6'h00;
        endcase
    endfunction

    function automatic logic [4:0] alu_of(kind_e k);
        case (k)
            K_ADD, K_ADDI, K_LW, K_SW: return 5'd1;
            K_SUB, K_BEQ, K_BNE:       return 5'd2;
            K_AND, K_ANDI:             return 5'd3;
            K_OR, K_ORI:               return 5'd4;
            K_SLT, K_SLTI:             return 5'd5;
            K_SLL:                     return 5'd6;
            K_SRL:                     return 5'd7;
            K_SRA:                     return 5'd8;
            K_LUI:                     return 5'd9;
            default:                   return 5'd0;
        endcase
    endfunction

    function automatic logic is_imm(kind_e k);
        return k inside {K_ADDI, K_SLTI, K_ANDI, K_ORI, K_LUI, K_LW, K_SW};
    endfunction

    function automatic logic [31:0] encode(kind_e k);
        logic [25:0] body;
        body = 26'($urandom);
        if (k <= K_JALR) return {6'b000000, body[25:6], funct_of(k)};
        return {op_of(k), body};
    endfunction

    // Phase codes: 0 FETCH, 1 DECODE, 2 EXE, 3 MEM, 4 WB, taken from the
    // per-instruction description of what happens in each step.
    function automatic ctl_t exp_ctl(kind_e k, int ph, logic rdy, logic z);
        ctl_t c;
        c = '0;
        case (ph)
            0: begin
                c.mem_read = 1'b1;
                c.pc_write = rdy;
                c.ir_write = rdy;
            end
            1: begin
                case (k)
                    K_J:    begin c.pc_write = 1'b1; c.npc_op = 2'b10; end
                    K_JAL:  begin c.pc_write = 1'b1; c.npc_op = 2'b10; c.reg_write = 1'b1;
                                  c.gpr_sel = 2'b10; c.wd_sel = 2'b10; end
                    K_JR:   begin c.pc_write = 1'b1; c.npc_op = 2'b11; end
                    K_JALR: begin c.pc_write = 1'b1; c.npc_op = 2'b11; c.reg_write = 1'b1;
                                  c.gpr_sel = 2'b00; c.wd_sel = 2'b10; end
                    default: ;
                endcase
            end
            2: begin
                c.alu_op   = alu_of(k);
                c.alu_src  = is_imm(k);
                c.ext_op   = k inside {K_ADDI, K_SLTI, K_LW, K_SW};
                c.areg_sel = k inside {K_SLL, K_SRL, K_SRA};
                if ((k == K_BEQ && z) || (k == K_BNE && !z)) begin
                    c.pc_write = 1'b1;
                    c.npc_op   = 2'b01;
                end
            end
            3: begin
                c.iord      = 1'b1;
                c.mem_read  = (k == K_LW);
                c.mem_write = (k == K_SW);
            end
            default: begin
                c.reg_write = 1'b1;
                if (k == K_LW) begin
                    c.wd_sel = 2'b01; c.gpr_sel = 2'b01;
                end else if (is_imm(k)) begin
                    c.gpr_sel = 2'b01;
                end
            end
        endcase
        return c;
    endfunction

    task automatic run_instr(input kind_e k, input logic z, input int f_stall, input int m_stall);
        int ph[$];
        instr = encode(k);
        Zero  = z;
        ph.push_back(0);
        ph.push_back(1);
        if (!(k inside {K_J, K_JAL, K_JR, K_JALR})) begin
            ph.push_back(2);
            if (k == K_LW) begin
                ph.push_back(3);
                ph.push_back(4);
            end else if (k == K_SW) begin
                ph.push_back(3);
            end else if (!(k inside {K_BEQ, K_BNE})) begin
                ph.push_back(4);
            end
        end
        foreach (ph[i]) begin
            int stall;
            stall = (ph[i] == 0) ? f_stall : (ph[i] == 3) ? m_stall : 0;
            for (int s = 0; s <= stall; s++) begin
                logic rdy;
                if (ph[i] == 0 || ph[i] == 3) rdy = (s == stall);
                else                          rdy = 1'($urandom_range(0, 1));
                mem_ready = rdy;
                @(negedge clk);
                check($sformatf("state k%0d", k), 32'(state), 32'(ph[i]));
                check($sformatf("ctl k%0d ph%0d", k, ph[i]), 32'(dut_ctl), 32'(exp_ctl(k, ph[i], rdy, z)));
                check($sformatf("nt_ctl k%0d ph%0d", k, ph[i]), 32'(nt_ctl), 32'(exp_ctl(k, ph[i], rdy, z)));
                check("retired", retired, 32'(n_retired));
                check("nt_retired_wrap", 32'(nt_retired), 32'(n_retired % 8));
                check("fault", 32'(fault), 32'(0));
                @(posedge clk);
                #1;
            end
        end
        n_retired++;
    endtask

    task automatic run_illegal(input logic [31:0] word);
        instr     = word;
        mem_ready = 1'b1;
        Zero      = 1'($urandom);
        @(negedge clk);
        check("ill_fetch_state", 32'(state), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("ill_decode_state", 32'(state), 32'(1));
        check("ill_decode_ctl", 32'(dut_ctl), 32'(0));
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            Zero      = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("ill_hold_state", 32'(state), 32'(7));
            check("ill_hold_fault", 32'(fault), 32'(1));
            check("ill_hold_nt_fault", 32'(nt_fault), 32'(1));
            check("ill_hold_ctl", 32'(dut_ctl), 32'(0));
            check("ill_hold_retired", retired, 32'(n_retired));
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        check("rst_pulse_state", 32'(state), 32'(0));
        check("rst_pulse_fault", 32'(fault), 32'(0));
        check("rst_pulse_retired", retired, 32'(0));
        check("rst_pulse_nt_retired", 32'(nt_retired), 32'(0));
        check("rst_pulse_ctl", 32'(dut_ctl), 32'(0));
        n_retired = 0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        ctl_t fetch_wait;
        fetch_wait = '0;
        fetch_wait.mem_read = 1'b1;

        instr     = $urandom;
        mem_ready = 1'b1;
        @(negedge clk);
        check("reset_state", 32'(state), 32'(0));
        check("reset_fault", 32'(fault), 32'(0));
        check("reset_retired", retired, 32'(0));
        check("reset_ctl", 32'(dut_ctl), 32'(0));
        check("reset_nt_ctl", 32'(nt_ctl), 32'(0));
        @(posedge clk); #1;
        rst = 1'b1;

        run_instr(K_ADDI, 1'b0, 0, 0);
        run_instr(K_BEQ,  1'b1, 0, 0);
        run_instr(K_BEQ,  1'b0, 0, 0);
        run_instr(K_LW,   1'b0, 0, 3);
        run_instr(K_JAL,  1'b0, 0, 0);
        run_instr(K_JALR, 1'b0, 0, 0);
        run_instr(K_SW,   1'b1, 2, 2);
        run_instr(K_BNE,  1'b0, 0, 0);
        run_instr(K_BNE,  1'b1, 1, 0);

        for (int n = 0; n < 250; n++) begin
            kind_e k;
            int    fs, ms;
            k  = kind_e'($urandom_range(0, K_N - 1));
            fs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            ms = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            run_instr(k, 1'($urandom_range(0, 1)), fs, ms);
        end

        run_illegal(32'hFC00_0000);
        run_illegal(32'h0000_003F);

        // Memory never answers the fetch: TIMEOUT=16 faults, TIMEOUT=0 waits on.
        instr     = {6'h08, 26'h0000005};
        mem_ready = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i < 16) begin
                check("to_wait_state", 32'(state), 32'(0));
                check("to_wait_fault", 32'(fault), 32'(0));
                check("to_wait_ctl", 32'(dut_ctl), 32'(fetch_wait));
            end else begin
                check("to_fault_state", 32'(state), 32'(7));
                check("to_fault_code", 32'(fault), 32'(2));
                check("to_fault_ctl", 32'(dut_ctl), 32'(0));
            end
            check("nt_wait_state", 32'(nt_state), 32'(0));
            check("nt_wait_fault", 32'(nt_fault), 32'(0));
            check("nt_wait_ctl", 32'(nt_ctl), 32'(fetch_wait));
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
